rd_addr_data_arbiter: RTL and testbench
=======================================

RD_ADDR_DATA_ARBITER -- requirements
Module: rd_addr_data_arbiter

Interface
REQ-001 SHALL have parameter BUFFER_SIZE, default 1024, data buffer depth in words.
REQ-002 SHALL have parameter NUM_CH, default 3, number of FSM3 read-address sources; legal range 1..15.
REQ-003 SHALL derive AW = log2(BUFFER_SIZE) and SELW = log2(NUM_CH+1), with log2(1)=1 and log2(v)=ceil(log2(v)) otherwise; HOLD = 2^SELW-1.
REQ-004 SHALL have clk, input, 1, rising-edge clock.
REQ-005 SHALL have rst, input, 1, reset, synchronous, active-low.
REQ-006 SHALL have ch_addr, input, NUM_CH*AW, channel i address in bits [i*AW +: AW].
REQ-007 SHALL have ch_req, input, NUM_CH, per-channel address-valid.
REQ-008 SHALL have ch_ack, output, NUM_CH, per-channel address-accepted, combinational.
REQ-009 SHALL have instr, input, SELW, channel select; value HOLD = release.
REQ-010 SHALL have instr_valid, input, 1, and instr_ready, output, 1; instr accepted when both high.
REQ-011 SHALL have rd_addr, output, AW, registered read address to FSM2.
REQ-012 SHALL have rd_valid, output, 1, and rd_ready, input, 1; beat transferred when both high.
REQ-013 SHALL have sel_out, output, SELW, current locked channel; locked, output, 1.
REQ-014 SHALL have err_bad_instr, output, 1, one-cycle registered pulse.
REQ-015 SHALL have beat_cnt, output, AW+1, beats issued since last lock change.

Function
REQ-016 SHALL implement states IDLE, LOCKED, DRAIN; locked=1 in LOCKED and DRAIN.
REQ-017 SHALL drive instr_ready=1 in IDLE and LOCKED, 0 in DRAIN and while rst=0.
REQ-018 Accepted instr in [NUM_CH, HOLD-1] SHALL pulse err_bad_instr next cycle and leave state, sel_out, rd_addr, beat_cnt unchanged.
REQ-019 IDLE + accepted legal channel instr SHALL go to LOCKED, sel_out<=instr, beat_cnt<=0; IDLE + HOLD SHALL be a no-op.
REQ-020 LOCKED + accepted legal instr (channel or HOLD): if rd_valid=1 and rd_ready=0 SHALL go DRAIN storing instr as pending; else SHALL apply next cycle (channel: LOCKED, new sel_out, beat_cnt<=0; HOLD: IDLE).
REQ-021 DRAIN SHALL apply the pending instr per REQ-020 in the cycle after rd_ready=1 is sampled with rd_valid=1.
REQ-022 Issue condition: state LOCKED, ch_req[sel_out]=1, (rd_valid=0 or rd_ready=1), and no instr accepted this cycle.
REQ-023 ch_ack SHALL be one-hot at bit sel_out exactly when the issue condition holds, else all zero.
REQ-024 On issue: rd_addr<=ch_addr[sel_out], rd_valid<=1, beat_cnt<=beat_cnt+1 saturating at 2^(AW+1)-1.
REQ-025 Without issue, rd_valid=1 and rd_ready=1 SHALL clear rd_valid next cycle; rd_valid=1 and rd_ready=0 SHALL hold rd_valid and rd_addr stable.
REQ-026 rd_addr SHALL hold its last value in IDLE, DRAIN and after HOLD; never returns to 0 except by reset.
REQ-027 Back-to-back issue SHALL sustain one beat per cycle while ch_req and rd_ready stay high.
REQ-028 Requests on non-selected channels SHALL be ignored and never acknowledged.

Reset
REQ-029 rst=0 sampled at a clock edge SHALL set state IDLE, sel_out 0, rd_addr 0, rd_valid 0, err_bad_instr 0, beat_cnt 0, pending cleared, regardless of in-flight beat or DRAIN.
REQ-030 While rst=0, ch_ack SHALL be all zero and instr_ready 0.

Verification
REQ-031 Reset: drive rst=0 one cycle mid-beat (rd_valid=1, rd_ready=0) -> next cycle rd_addr=0, rd_valid=0, state IDLE, beat_cnt=0.
REQ-032 Stream: NUM_CH=3, instr=1 accepted, ch_req[1]=1, ch_addr ch1 = 0x010,0x011,0x012, rd_ready=1 -> rd_addr 0x010,0x011,0x012 on consecutive cycles, ch_ack=3'b010 each cycle, beat_cnt=3.
REQ-033 Backpressure: rd_valid=1, rd_addr=0x3FF, rd_ready=0 for 4 cycles -> rd_addr stays 0x3FF, ch_ack=0; rd_ready=1 -> next beat issued same cycle.
REQ-034 Switch during stall: locked ch0, rd_ready=0, instr=2 accepted -> DRAIN, instr_ready=0; rd_ready=1 -> sel_out=2, beat_cnt=0, ch_ack[0] never asserted after instr acceptance.
REQ-035 Bad instr: NUM_CH=5 (SELW=3, HOLD=7), instr=6 accepted -> err_bad_instr=1 one cycle, sel_out unchanged; instr=7 -> IDLE, rd_addr held.
REQ-036 Non-power-of-2: BUFFER_SIZE=1000 (AW=10), BUFFER_SIZE=1 (AW=1) -> elaborate and pass REQ-032.

Source files
------------

// File: rtl/rd_addr_data_arbiter.sv
// rd_addr_data_arbiter
//   Locks onto one of NUM_CH read-address sources, selected by a command
//   stream (instr), and forwards that channel's addresses to the data-side
//   FSM as a registered valid/ready stream. A channel switch requested while
//   a beat is stalled waits in DRAIN until the stalled beat is accepted.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous reset, active low
//   ch_addr       packed channel addresses, channel i in [i*AW +: AW]
//   ch_req        per-channel address valid
//   ch_ack        per-channel address accepted (combinational, one-hot)
//   instr         channel select command; all-ones (HOLD) releases the lock
//   instr_valid   command valid
//   instr_ready   command ready (low in DRAIN and during reset)
//   rd_addr       registered read address
//   rd_valid      read address valid
//   rd_ready      read address accepted by the consumer
//   sel_out       currently selected channel
//   locked        high while a channel is held (LOCKED or DRAIN)
//   err_bad_instr one-cycle pulse after an out-of-range command
//   beat_cnt      beats issued since the last lock change (saturating)

module rd_addr_data_arbiter #(
  parameter int BUFFER_SIZE = 1024,
  parameter int NUM_CH      = 3,
  localparam int AW   = (BUFFER_SIZE <= 1) ? 1 : $clog2(BUFFER_SIZE),
  localparam int SELW = ((NUM_CH + 1) <= 1) ? 1 : $clog2(NUM_CH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH*AW-1:0] ch_addr,
  input  logic [NUM_CH-1:0]    ch_req,
  output logic [NUM_CH-1:0]    ch_ack,
  input  logic [SELW-1:0]      instr,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  output logic [AW-1:0]        rd_addr,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [SELW-1:0]      sel_out,
  output logic                 locked,
  output logic                 err_bad_instr,
  output logic [AW:0]          beat_cnt
);

  localparam logic [SELW-1:0] HOLD_CODE = '1;
  localparam logic [SELW-1:0] NUM_CH_W  = SELW'(NUM_CH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCKED = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t          state;
  logic [SELW-1:0] pending;

  logic            instr_fire;
  logic            instr_bad;
  logic            instr_legal;
  logic            req_sel;
  logic [AW-1:0]   addr_sel;
  logic            issue;
  logic            stalled;
  logic            go_drain;
  logic            apply_now;
  logic [SELW-1:0] apply_code;

  assign instr_ready = rst && (state != DRAIN);
  assign instr_fire  = instr_valid && instr_ready;
  // Codes between the last channel and HOLD name no channel.
  assign instr_bad   = instr_fire && (instr >= NUM_CH_W) && (instr != HOLD_CODE);
  assign instr_legal = instr_fire && !instr_bad;
  assign stalled     = rd_valid && !rd_ready;

  // Mux the selected channel's request and address.
  always_comb begin
    req_sel  = 1'b0;
    addr_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel_out == SELW'(i)) begin
        req_sel  = ch_req[i];
        addr_sel = ch_addr[i*AW +: AW];
      end
    end
  end

  // A command accepted this cycle takes priority over issuing a beat, so the
  // old channel is never acknowledged once a switch has been accepted.
  assign issue = rst && (state == LOCKED) && req_sel && !stalled && !instr_fire;

  always_comb begin
    ch_ack = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_ack[i] = issue && (sel_out == SELW'(i));
    end
  end

  // Decide whether a command takes effect at this edge, and which one.
  always_comb begin
    go_drain   = 1'b0;
    apply_now  = 1'b0;
    apply_code = instr;
    case (state)
      IDLE: begin
        apply_now = instr_legal;
      end
      LOCKED: begin
        go_drain  = instr_legal && stalled;
        apply_now = instr_legal && !stalled;
      end
      DRAIN: begin
        apply_now  = !stalled;
        apply_code = pending;
      end
      default: begin
        apply_now = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      locked        <= 1'b0;
      sel_out       <= '0;
      pending       <= '0;
      rd_addr       <= '0;
      rd_valid      <= 1'b0;
      err_bad_instr <= 1'b0;
      beat_cnt      <= '0;
    end else begin
      err_bad_instr <= instr_bad;

      if (issue) begin
        rd_addr  <= addr_sel;
        rd_valid <= 1'b1;
        if (beat_cnt != '1) begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end else if (rd_valid && rd_ready) begin
        rd_valid <= 1'b0;
      end

      // Issue never coincides with a command taking effect, so the
      // beat_cnt writes below cannot collide with the increment above.
      if (go_drain) begin
        state   <= DRAIN;
        pending <= instr;
      end else if (apply_now) begin
        if (apply_code == HOLD_CODE) begin
          state  <= IDLE;
          locked <= 1'b0;
        end else begin
          state    <= LOCKED;
          locked   <= 1'b1;
          sel_out  <= apply_code;
          beat_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rd_addr_data_arbiter.sv
// tb_rd_addr_data_arbiter
//   Directed bench for rd_addr_data_arbiter. Three instances share clock and
//   reset: the default configuration (1024 words, 3 channels), a 5-channel
//   1000-word instance for out-of-range commands, and a 1-word instance for
//   the minimum address width and beat counter saturation. Expected read
//   addresses are queued when a beat is issued; per-instance monitors pop and
//   compare whenever a beat is transferred.

module tb_rd_addr_data_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  // default instance: AW=10, SELW=2, HOLD=3
  logic [29:0] ch_addr = '0;
  logic [2:0]  ch_req = '0;
  logic [2:0]  ch_ack;
  logic [1:0]  instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [9:0]  rd_addr;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [1:0]  sel_out;
  logic        locked;
  logic        err_bad_instr;
  logic [10:0] beat_cnt;

  // five-channel instance: AW=10, SELW=3, HOLD=7
  logic [49:0] ch_addr_b = '0;
  logic [4:0]  ch_req_b = '0;
  logic [4:0]  ch_ack_b;
  logic [2:0]  instr_b = '0;
  logic        instr_valid_b = 1'b0;
  logic        instr_ready_b;
  logic [9:0]  rd_addr_b;
  logic        rd_valid_b;
  logic        rd_ready_b = 1'b0;
  logic [2:0]  sel_out_b;
  logic        locked_b;
  logic        err_bad_instr_b;
  logic [10:0] beat_cnt_b;

  // one-word instance: AW=1, SELW=2
  logic [2:0]  ch_addr_c = '0;
  logic [2:0]  ch_req_c = '0;
  logic [2:0]  ch_ack_c;
  logic [1:0]  instr_c = '0;
  logic        instr_valid_c = 1'b0;
  logic        instr_ready_c;
  logic [0:0]  rd_addr_c;
  logic        rd_valid_c;
  logic        rd_ready_c = 1'b0;
  logic [1:0]  sel_out_c;
  logic        locked_c;
  logic        err_bad_instr_c;
  logic [1:0]  beat_cnt_c;

  rd_addr_data_arbiter #(.BUFFER_SIZE(1024), .NUM_CH(3)) dut (
    .clk(clk), .rst(rst), .ch_addr(ch_addr), .ch_req(ch_req), .ch_ack(ch_ack),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .sel_out(sel_out), .locked(locked), .err_bad_instr(err_bad_instr),
    .beat_cnt(beat_cnt)
  );

  rd_addr_data_arbiter #(.BUFFER_SIZE(1000), .NUM_CH(5)) dut_b (
    .clk(clk), .rst(rst), .ch_addr(ch_addr_b), .ch_req(ch_req_b), .ch_ack(ch_ack_b),
    .instr(instr_b), .instr_valid(instr_valid_b), .instr_ready(instr_ready_b),
    .rd_addr(rd_addr_b), .rd_valid(rd_valid_b), .rd_ready(rd_ready_b),
    .sel_out(sel_out_b), .locked(locked_b), .err_bad_instr(err_bad_instr_b),
    .beat_cnt(beat_cnt_b)
  );

  rd_addr_data_arbiter #(.BUFFER_SIZE(1), .NUM_CH(3)) dut_c (
    .clk(clk), .rst(rst), .ch_addr(ch_addr_c), .ch_req(ch_req_c), .ch_ack(ch_ack_c),
    .instr(instr_c), .instr_valid(instr_valid_c), .instr_ready(instr_ready_c),
    .rd_addr(rd_addr_c), .rd_valid(rd_valid_c), .rd_ready(rd_ready_c),
    .sel_out(sel_out_c), .locked(locked_c), .err_bad_instr(err_bad_instr_c),
    .beat_cnt(beat_cnt_c)
  );

  int check_count = 0;
  int pass_count  = 0;

  logic [9:0] exp_q[$];
  logic [9:0] exp_q_b[$];
  logic [0:0] exp_q_c[$];

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the default instance's handshake inputs, then let them settle.
  task automatic apply_stimulus(input logic [2:0] req, input logic rdy,
                                input logic ival, input logic [1:0] ins);
    ch_req      = req;
    rd_ready    = rdy;
    instr_valid = ival;
    instr       = ins;
    #1;
  endtask

  // Scoreboard monitors: one per instance, sampling mid-cycle.
  always @(negedge clk) begin
    if (rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        check_output("beat_unexpected", 32'(rd_addr), 32'hFFFF_FFFF);
      end else begin
        check_output("beat_addr", 32'(rd_addr), 32'(exp_q.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (rd_valid_b && rd_ready_b) begin
      if (exp_q_b.size() == 0) begin
        check_output("beat_unexpected_b", 32'(rd_addr_b), 32'hFFFF_FFFF);
      end else begin
        check_output("beat_addr_b", 32'(rd_addr_b), 32'(exp_q_b.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (rd_valid_c && rd_ready_c) begin
      if (exp_q_c.size() == 0) begin
        check_output("beat_unexpected_c", 32'(rd_addr_c), 32'hFFFF_FFFF);
      end else begin
        check_output("beat_addr_c", 32'(rd_addr_c), 32'(exp_q_c.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state, with requests present to prove ch_ack stays quiet.
    apply_stimulus(3'b111, 1'b0, 1'b0, 2'd0);
    repeat (3) tick();
    check_output("rst_instr_ready", 32'(instr_ready), 0);
    check_output("rst_ch_ack", 32'(ch_ack), 0);
    check_output("rst_rd_valid", 32'(rd_valid), 0);
    check_output("rst_rd_addr", 32'(rd_addr), 0);
    check_output("rst_locked", 32'(locked), 0);
    check_output("rst_beat_cnt", 32'(beat_cnt), 0);
    check_output("rst_instr_ready_b", 32'(instr_ready_b), 0);
    rst = 1'b1;
    apply_stimulus(3'b000, 1'b1, 1'b1, 2'd1);
    check_output("idle_instr_ready", 32'(instr_ready), 1);
    tick();

    // Stream three beats from channel 1.
    apply_stimulus(3'b000, 1'b1, 1'b0, 2'd0);
    check_output("lock_locked", 32'(locked), 1);
    check_output("lock_sel_out", 32'(sel_out), 1);
    check_output("lock_beat_cnt", 32'(beat_cnt), 0);
    for (int k = 0; k < 3; k++) begin
      ch_addr[10 +: 10] = 10'h010 + 10'(k);
      apply_stimulus(3'b010, 1'b1, 1'b0, 2'd0);
      check_output("stream_ch_ack", 32'(ch_ack), 'b010);
      exp_q.push_back(10'h010 + 10'(k));
      tick();
    end
    apply_stimulus(3'b000, 1'b1, 1'b0, 2'd0);
    check_output("stream_beat_cnt", 32'(beat_cnt), 3);
    check_output("stream_rd_addr", 32'(rd_addr), 'h012);
    tick();
    check_output("stream_rd_valid_clear", 32'(rd_valid), 0);

    // Backpressure on a 0x3FF beat for four cycles.
    ch_addr[10 +: 10] = 10'h3FF;
    apply_stimulus(3'b010, 1'b1, 1'b0, 2'd0);
    exp_q.push_back(10'h3FF);
    tick();
    ch_addr[10 +: 10] = 10'h100;
    apply_stimulus(3'b010, 1'b0, 1'b0, 2'd0);
    for (int k = 0; k < 4; k++) begin
      check_output("bp_rd_addr", 32'(rd_addr), 'h3FF);
      check_output("bp_rd_valid", 32'(rd_valid), 1);
      check_output("bp_ch_ack", 32'(ch_ack), 0);
      if (k < 3) tick();
    end
    apply_stimulus(3'b010, 1'b1, 1'b0, 2'd0);
    check_output("bp_release_ch_ack", 32'(ch_ack), 'b010);
    exp_q.push_back(10'h100);
    tick();
    apply_stimulus(3'b000, 1'b1, 1'b0, 2'd0);
    check_output("bp_rd_addr_next", 32'(rd_addr), 'h100);
    check_output("bp_beat_cnt", 32'(beat_cnt), 5);
    tick();

    // Switch to channel 0 while idle on the stream, then to 2 during a stall.
    apply_stimulus(3'b000, 1'b1, 1'b1, 2'd0);
    tick();
    apply_stimulus(3'b000, 1'b1, 1'b0, 2'd0);
    check_output("sw0_sel_out", 32'(sel_out), 0);
    check_output("sw0_beat_cnt", 32'(beat_cnt), 0);
    ch_addr[0 +: 10] = 10'h020;
    apply_stimulus(3'b001, 1'b1, 1'b0, 2'd0);
    check_output("sw0_ch_ack", 32'(ch_ack), 'b001);
    exp_q.push_back(10'h020);
    tick();
    apply_stimulus(3'b001, 1'b0, 1'b1, 2'd2);
    check_output("sw_accept_ch_ack", 32'(ch_ack), 0);
    check_output("sw_accept_instr_ready", 32'(instr_ready), 1);
    tick();
    apply_stimulus(3'b001, 1'b0, 1'b0, 2'd0);
    check_output("drain_locked", 32'(locked), 1);
    check_output("drain_instr_ready", 32'(instr_ready), 0);
    check_output("drain_ch_ack", 32'(ch_ack), 0);
    check_output("drain_sel_out", 32'(sel_out), 0);
    tick();
    check_output("drain_ch_ack_2", 32'(ch_ack), 0);
    check_output("drain_rd_addr", 32'(rd_addr), 'h020);
    apply_stimulus(3'b001, 1'b1, 1'b0, 2'd0);
    check_output("drain_release_ch_ack", 32'(ch_ack), 0);
    tick();
    check_output("sw2_sel_out", 32'(sel_out), 2);
    check_output("sw2_beat_cnt", 32'(beat_cnt), 0);
    check_output("sw2_rd_valid", 32'(rd_valid), 0);
    check_output("sw2_instr_ready", 32'(instr_ready), 1);
    check_output("sw2_old_ch_ack", 32'(ch_ack), 0);
    ch_addr[20 +: 10] = 10'h222;
    apply_stimulus(3'b101, 1'b1, 1'b0, 2'd0);
    check_output("sw2_ch_ack", 32'(ch_ack), 'b100);
    exp_q.push_back(10'h222);
    tick();
    apply_stimulus(3'b000, 1'b1, 1'b0, 2'd0);
    tick();

    // Release with HOLD: address is retained, requests ignored.
    apply_stimulus(3'b000, 1'b1, 1'b1, 2'd3);
    tick();
    apply_stimulus(3'b010, 1'b1, 1'b0, 2'd0);
    check_output("hold_locked", 32'(locked), 0);
    check_output("hold_rd_addr", 32'(rd_addr), 'h222);
    check_output("hold_ch_ack", 32'(ch_ack), 0);
    tick();
    check_output("hold_rd_valid", 32'(rd_valid), 0);

    // Reset in the middle of a stalled beat.
    apply_stimulus(3'b000, 1'b0, 1'b1, 2'd1);
    tick();
    ch_addr[10 +: 10] = 10'h155;
    apply_stimulus(3'b010, 1'b0, 1'b0, 2'd0);
    check_output("mid_ch_ack", 32'(ch_ack), 'b010);
    tick();
    check_output("mid_rd_valid", 32'(rd_valid), 1);
    check_output("mid_rd_addr", 32'(rd_addr), 'h155);
    rst = 1'b0;
    #1;
    check_output("mid_rst_instr_ready", 32'(instr_ready), 0);
    check_output("mid_rst_ch_ack", 32'(ch_ack), 0);
    tick();
    check_output("mid_rst_rd_addr", 32'(rd_addr), 0);
    check_output("mid_rst_rd_valid", 32'(rd_valid), 0);
    check_output("mid_rst_locked", 32'(locked), 0);
    check_output("mid_rst_beat_cnt", 32'(beat_cnt), 0);
    check_output("mid_rst_sel_out", 32'(sel_out), 0);
    rst = 1'b1;
    apply_stimulus(3'b000, 1'b0, 1'b0, 2'd0);

    // One-word instance: 1-bit addresses and beat counter saturation at 3.
    instr_c = 2'd1;
    instr_valid_c = 1'b1;
    rd_ready_c = 1'b1;
    tick();
    instr_valid_c = 1'b0;
    for (int k = 0; k < 5; k++) begin
      ch_addr_c[1] = (k % 2 == 0);
      ch_req_c = 3'b010;
      #1;
      check_output("c_ch_ack", 32'(ch_ack_c), 'b010);
      exp_q_c.push_back(1'((k % 2) == 0));
      tick();
    end
    ch_req_c = 3'b000;
    #1;
    check_output("c_beat_cnt_sat", 32'(beat_cnt_c), 3);
    check_output("c_rd_addr", 32'(rd_addr_c), 1);
    tick();

    // Five-channel instance: out-of-range commands and HOLD=7.
    instr_b = 3'd4;
    instr_valid_b = 1'b1;
    rd_ready_b = 1'b1;
    tick();
    instr_valid_b = 1'b0;
    ch_addr_b[40 +: 10] = 10'h3E7;
    ch_req_b = 5'b10000;
    #1;
    check_output("b_ch_ack", 32'(ch_ack_b), 'b10000);
    exp_q_b.push_back(10'h3E7);
    tick();
    ch_req_b = 5'b00000;
    instr_b = 3'd6;
    instr_valid_b = 1'b1;
    #1;
    check_output("b_bad_instr_ready", 32'(instr_ready_b), 1);
    tick();
    instr_valid_b = 1'b0;
    #1;
    check_output("b_err_pulse", 32'(err_bad_instr_b), 1);
    check_output("b_err_sel_out", 32'(sel_out_b), 4);
    check_output("b_err_locked", 32'(locked_b), 1);
    check_output("b_err_rd_addr", 32'(rd_addr_b), 'h3E7);
    check_output("b_err_beat_cnt", 32'(beat_cnt_b), 1);
    tick();
    check_output("b_err_clear", 32'(err_bad_instr_b), 0);
    instr_b = 3'd7;
    instr_valid_b = 1'b1;
    tick();
    instr_valid_b = 1'b0;
    #1;
    check_output("b_hold_locked", 32'(locked_b), 0);
    check_output("b_hold_rd_addr", 32'(rd_addr_b), 'h3E7);
    check_output("b_hold_err", 32'(err_bad_instr_b), 0);
    instr_b = 3'd5;
    instr_valid_b = 1'b1;
    tick();
    instr_valid_b = 1'b0;
    #1;
    check_output("b_idle_err_pulse", 32'(err_bad_instr_b), 1);
    check_output("b_idle_err_locked", 32'(locked_b), 0);
    tick();
    check_output("b_idle_err_clear", 32'(err_bad_instr_b), 0);

    // Every queued beat must have been transferred.
    tick();
    check_output("queue_empty", 32'(exp_q.size()), 0);
    check_output("queue_empty_b", 32'(exp_q_b.size()), 0);
    check_output("queue_empty_c", 32'(exp_q_c.size()), 0);

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
